// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// Latency: n/a (types only). Backpressure: n/a.
// Optional loss counter is controlled in the top via PLL_SEQ_LOSS_CNT_EN.
package pll_seq_pkg;

    localparam int PLL_SEQ_STATE_W = 3;
    localparam int PLL_SEQ_RETRY_W = 8;

    typedef enum logic [PLL_SEQ_STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_PWRDN     = 3'd1,
        ST_RESET     = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_STABLE    = 3'd4,
        ST_RUN       = 3'd5,
        ST_FAULT     = 3'd6
    } pll_seq_state_t;

    // Saturating 8-bit increment shared by the retry and loss counters.
    function automatic logic [PLL_SEQ_RETRY_W-1:0] sat_inc8(input logic [PLL_SEQ_RETRY_W-1:0] v);
        return (v == '1) ? v : v + PLL_SEQ_RETRY_W'(1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level into clk.
// Latency: 2 cycles. Backpressure: none.
// Both stages clear on synchronous active-low rst_n.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_rst_sequencer.sv
// PLL power-down / reset / lock-qualify sequencer; PLL_SEQ_LOSS_CNT_EN adds loss_cnt.
// Latency: outputs registered, decoded from the state being entered (same edge as state).
// Backpressure: none; start is a one-cycle request, pwrdwn_req a level.
module pll_rst_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT    = 4096,
    parameter int unsigned LOCK_STABLE     = 64,
    parameter int unsigned MAX_RETRIES     = 3,
    parameter int unsigned CNT_W           = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       pwrdwn_req,
    input  logic                       pll_locked,
    output logic                       pll_rst,
    output logic                       pll_pwrdwn,
    output logic                       ready,
    output logic                       fault,
    output logic [PLL_SEQ_STATE_W-1:0] state_o,
    output logic [PLL_SEQ_RETRY_W-1:0] retry_cnt
`ifdef PLL_SEQ_LOSS_CNT_EN
    ,
    output logic [7:0]                 loss_cnt
`endif
);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [PLL_SEQ_RETRY_W-1:0] RETRY_LAST = PLL_SEQ_RETRY_W'(MAX_RETRIES - 1);

    pll_seq_state_t             state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [PLL_SEQ_RETRY_W-1:0] retry_q, retry_d;
    logic                       pll_rst_q, pll_rst_d;
    logic                       pll_pwrdwn_q, pll_pwrdwn_d;
    logic                       ready_q, ready_d;
    logic                       fault_q, fault_d;
    logic                       lock_s;
`ifdef PLL_SEQ_LOSS_CNT_EN
    logic [7:0]                 loss_q, loss_d;
`endif

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pll_locked),
        .q_o   (lock_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
`ifdef PLL_SEQ_LOSS_CNT_EN
        loss_d  = loss_q;
`endif
        if (pwrdwn_req) begin
            state_d = ST_PWRDN;
            cnt_d   = '0;
        end else if (start && (state_q != ST_PWRDN)) begin
            state_d = ST_RESET;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                // Leaving power-down always restarts with a full reset pulse.
                ST_PWRDN: begin
                    state_d = ST_RESET;
                    cnt_d   = '0;
                    retry_d = '0;
                end
                ST_RESET: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        retry_d = sat_inc8(retry_q);
                        cnt_d   = '0;
                        state_d = (retry_q == RETRY_LAST) ? ST_FAULT : ST_RESET;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_d = ST_RESET;
                        cnt_d   = '0;
`ifdef PLL_SEQ_LOSS_CNT_EN
                        loss_d  = sat_inc8(loss_q);
`endif
                    end
                end
                ST_FAULT: ;
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        pll_rst_d    = (state_d == ST_IDLE) || (state_d == ST_PWRDN) ||
                       (state_d == ST_RESET) || (state_d == ST_FAULT);
        pll_pwrdwn_d = (state_d == ST_PWRDN);
        ready_d      = (state_d == ST_RUN);
        fault_d      = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            retry_q      <= '0;
            pll_rst_q    <= 1'b1;
            pll_pwrdwn_q <= 1'b0;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            pll_rst_q    <= pll_rst_d;
            pll_pwrdwn_q <= pll_pwrdwn_d;
            ready_q      <= ready_d;
            fault_q      <= fault_d;
        end
    end

`ifdef PLL_SEQ_LOSS_CNT_EN
    // Only rst_n clears the loss history; a restart keeps it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            loss_q <= '0;
        end else begin
            loss_q <= loss_d;
        end
    end

    assign loss_cnt = loss_q;
`endif

    assign pll_rst    = pll_rst_q;
    assign pll_pwrdwn = pll_pwrdwn_q;
    assign ready      = ready_q;
    assign fault      = fault_q;
    assign state_o    = state_q;
    assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_pll_rst_sequencer.sv
// Directed bench for pll_rst_sequencer with a tag/value expectation queue.
// Cycle n is the interval just after rising edge n; inputs change and outputs are sampled 1ns after the edge.
module tb_pll_rst_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       pwrdwn_req;
    logic       pll_locked;
    logic       pll_rst;
    logic       pll_pwrdwn;
    logic       ready;
    logic       fault;
    logic [2:0] state_o;
    logic [7:0] retry_cnt;
`ifdef PLL_SEQ_LOSS_CNT_EN
    logic [7:0] loss_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    string       sb_tag[$];
    logic [31:0] sb_val[$];

    pll_rst_sequencer #(
        .RST_HOLD_CYCLES (16),
        .LOCK_TIMEOUT    (256),
        .LOCK_STABLE     (8),
        .MAX_RETRIES     (2),
        .CNT_W           (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pwrdwn_req (pwrdwn_req),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .pll_pwrdwn (pll_pwrdwn),
        .ready      (ready),
        .fault      (fault),
        .state_o    (state_o),
        .retry_cnt  (retry_cnt)
`ifdef PLL_SEQ_LOSS_CNT_EN
        ,
        .loss_cnt   (loss_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic expect_v(input string tag, input logic [31:0] v);
        sb_tag.push_back(tag);
        sb_val.push_back(v);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        checks++;
        if (sb_val.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0d", obs);
        end else begin
            t = sb_tag.pop_front();
            e = sb_val.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%0d expected=%0d", t, obs, e);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        expect_v(tag, exp);
        pop_chk(obs);
    endtask

    // Returns the first cycle at which ready equals val, or -1 on expiry.
    task automatic wait_ready(input logic val, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            if (ready === val) begin
                at = cyc;
                break;
            end
            tick();
        end
    endtask

    initial begin
        int b;
        int at;
        int hi;

        rst_n      = 1'b0;
        start      = 1'b0;
        pwrdwn_req = 1'b0;
        pll_locked = 1'b0;

        // Reset values
        tick(); tick(); tick();
        chk("rst_pll_rst",    pll_rst,    1);
        chk("rst_pll_pwrdwn", pll_pwrdwn, 0);
        chk("rst_ready",      ready,      0);
        chk("rst_fault",      fault,      0);
        chk("rst_state",      state_o,    0);
        chk("rst_retry",      retry_cnt,  0);
`ifdef PLL_SEQ_LOSS_CNT_EN
        chk("rst_loss", loss_cnt, 0);
`endif
        rst_n = 1'b1;

        // 1: start at cycle 10, lock at cycle 40
        tick_to(10);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_state_reset", state_o, 2);
        hi = 0;
        for (int k = 0; k < 16; k++) begin
            if (pll_rst === 1'b1) hi++;
            tick();
        end
        chk("t1_rst_hi_cycles", hi, 16);
        chk("t1_rst_low_c27",   pll_rst, 0);
        chk("t1_state_wait_c27", state_o, 3);
        tick_to(40);
        pll_locked = 1'b1;
        expect_v("t1_ready_cycle", cyc + 11);
        wait_ready(1'b1, 40, at);
        pop_chk(at);
        chk("t1_retry", retry_cnt, 0);

        // 3: one-cycle lock loss in RUN
        b = cyc;
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        expect_v("t3_ready_drop_cycle", b + 3);
        wait_ready(1'b0, 10, at);
        pop_chk(at);
        chk("t3_state_reset", state_o, 2);
        chk("t3_retry",       retry_cnt, 0);
        chk("t3_pll_rst",     pll_rst, 1);
`ifdef PLL_SEQ_LOSS_CNT_EN
        chk("t3_loss", loss_cnt, 1);
`endif

        // 4: glitch seen by STABLE at cnt=5
        tick_to(b + 23);
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        tick_to(b + 25);
        chk("t4_state_stable", state_o, 4);
        tick();
        chk("t4_state_wait", state_o, 3);
        chk("t4_retry",      retry_cnt, 0);
        expect_v("t4_ready_cycle", b + 35);
        wait_ready(1'b1, 30, at);
        pop_chk(at);

        // 5: power-down in RUN with start asserted meanwhile
        b = cyc;
        pwrdwn_req = 1'b1;
        tick();
        chk("t5_pwrdwn",     pll_pwrdwn, 1);
        chk("t5_ready_off",  ready, 0);
        chk("t5_state_pd",   state_o, 1);
        tick_to(b + 6);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick_to(b + 10);
        chk("t5_state_pd_hold", state_o, 1);
        chk("t5_pll_rst_pd",    pll_rst, 1);
        tick_to(b + 20);
        pwrdwn_req = 1'b0;
        tick();
        chk("t5_state_reset", state_o, 2);
        chk("t5_pwrdwn_off",  pll_pwrdwn, 0);
        hi = 0;
        for (int k = 0; k < 16; k++) begin
            if (pll_rst === 1'b1) hi++;
            tick();
        end
        chk("t5_rst_hi_cycles", hi, 16);
        chk("t5_state_wait",    state_o, 3);
        expect_v("t5_ready_cycle", b + 46);
        wait_ready(1'b1, 30, at);
        pop_chk(at);

        // 2: lock never arrives -> two timeouts -> FAULT
        b = cyc;
        pll_locked = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t2_ready_off", ready, 0);
        tick_to(b + 272);
        chk("t2_state_wait_last", state_o, 3);
        chk("t2_retry_before",    retry_cnt, 0);
        tick();
        chk("t2_state_retry1", state_o, 2);
        chk("t2_retry1",       retry_cnt, 1);
        tick_to(b + 544);
        chk("t2_state_wait_last2", state_o, 3);
        chk("t2_fault_before",     fault, 0);
        tick();
        chk("t2_fault",     fault, 1);
        chk("t2_state_flt", state_o, 6);
        chk("t2_pll_rst",   pll_rst, 1);
        chk("t2_retry2",    retry_cnt, 2);
        tick_to(b + 550);
        chk("t2_fault_hold", state_o, 6);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t2_fault_clear", fault, 0);
        chk("t2_retry_clear", retry_cnt, 0);
        chk("t2_state_reset", state_o, 2);
`ifdef PLL_SEQ_LOSS_CNT_EN
        chk("t2_loss_kept", loss_cnt, 1);
`endif

        // 6: rst_n pulse during the second WAIT_LOCK of a new attempt
        b = cyc;
        tick_to(b + 272);
        chk("t6_retry1", retry_cnt, 1);
        tick_to(b + 300);
        chk("t6_state_wait", state_o, 3);
        pll_locked = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t6_state_idle", state_o, 0);
        chk("t6_pll_rst",    pll_rst, 1);
        chk("t6_retry0",     retry_cnt, 0);
        chk("t6_fault0",     fault, 0);
        chk("t6_ready0",     ready, 0);
`ifdef PLL_SEQ_LOSS_CNT_EN
        chk("t6_loss0", loss_cnt, 0);
`endif
        tick_to(cyc + 8);
        chk("t6_idle_hold", state_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
